// File: rtl/twiddle_sched_if.sv
// twiddle_sched_if: row-stream bus between the first 8-point FFT stage,
// the inter-stage twiddle scheduler, and the second 8-point stage.
// master = upstream/downstream environment, slave = twiddle_sched.
interface twiddle_sched_if #(
  parameter int W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [8*W-1:0]   in_re;
  logic [8*W-1:0]   in_im;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [8*W-1:0]   out_re;
  logic [8*W-1:0]   out_im;
  logic [2:0]       out_row;
  logic             out_last;
  logic             err;

  modport master (
    output in_valid, in_re, in_im, in_last, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_row, out_last, err
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, out_ready,
    output in_ready, out_valid, out_re, out_im, out_row, out_last, err
  );
endinterface

// File: rtl/twiddle_sched.sv
// twiddle_sched: inter-stage twiddle sequencer for the 64-point FFT.
// Accepts one 8-sample row per beat, multiplies samples 1..7 of row k by
// W64^(n*k) (row 0 bypassed), and delivers the result through a 2-stage
// valid/ready pipeline.
// Optional feature macro: TWID_FRAME_CHK_EN (in_last frame check, sticky
// err, row resync). Without it in_last is ignored and err is tied low.

// Constant twiddle multiplier for row K (instance K plays the role of multiK).
// Twiddle for sample n is cos(2*pi*n*K/64) - j*sin(2*pi*n*K/64) in Q8;
// products are floored by the shift and wrap to W bits.
module twid_multi #(
  parameter int W = 10,
  parameter int K = 1
) (
  input  logic [7*W-1:0] in_re,
  input  logic [7*W-1:0] in_im,
  output logic [7*W-1:0] out_re,
  output logic [7*W-1:0] out_im
);
  localparam int FRAC = 8;

  // round(256*cos(2*pi*i/64)) for the first quarter wave
  function automatic int cos_quarter(input int i);
    int r;
    case (i)
      0:       r = 256;
      1:       r = 255;
      2:       r = 251;
      3:       r = 245;
      4:       r = 237;
      5:       r = 226;
      6:       r = 213;
      7:       r = 198;
      8:       r = 181;
      9:       r = 162;
      10:      r = 142;
      11:      r = 121;
      12:      r = 98;
      13:      r = 74;
      14:      r = 50;
      15:      r = 25;
      default: r = 0;
    endcase
    return r;
  endfunction

  // full-circle cosine by quarter-wave symmetry, m in 0..63
  function automatic int cos_q8(input int m);
    int r;
    if (m <= 16)      r = cos_quarter(m);
    else if (m <= 32) r = -cos_quarter(32 - m);
    else if (m <= 48) r = -cos_quarter(m - 32);
    else              r = cos_quarter(64 - m);
    return r;
  endfunction

  for (genvar gi = 0; gi < 7; gi++) begin : g_smp
    localparam int M = (K * (gi + 1)) % 64;
    // sin(m) = cos(m - 16) = cos(m + 48)
    localparam logic [2*W:0] CC = (2*W+1)'(cos_q8(M));
    localparam logic [2*W:0] SS = (2*W+1)'(cos_q8((M + 48) % 64));
    logic [2*W:0] a_ext;
    logic [2*W:0] b_ext;
    assign a_ext = {{(W+1){in_re[gi*W+W-1]}}, in_re[gi*W +: W]};
    assign b_ext = {{(W+1){in_im[gi*W+W-1]}}, in_im[gi*W +: W]};
    // (a + jb)(c - js) = (ac + bs) + j(bc - as); low bits of the
    // sign-extended product are exact two's-complement results
    assign out_re[gi*W +: W] = W'((a_ext * CC + b_ext * SS) >> FRAC);
    assign out_im[gi*W +: W] = W'((b_ext * CC - a_ext * SS) >> FRAC);
  end
endmodule

module twiddle_sched #(
  parameter int W = 10
) (
  input  logic          clk,
  input  logic          rst,
  twiddle_sched_if.slave bus
);
  localparam int RW = 8 * W;

  logic          s1_adv;
  logic          s2_adv;
  logic          in_fire;

  logic [2:0]    row_q, row_d;
  logic          err_q, err_d;

  logic          s1_valid_q, s1_valid_d;
  logic [RW-1:0] s1_re_q, s1_re_d;
  logic [RW-1:0] s1_im_q, s1_im_d;
  logic [2:0]    s1_row_q, s1_row_d;

  logic          s2_valid_q, s2_valid_d;
  logic [RW-1:0] s2_re_q, s2_re_d;
  logic [RW-1:0] s2_im_q, s2_im_d;
  logic [2:0]    s2_row_q, s2_row_d;
  logic          s2_last_q, s2_last_d;

  logic [RW-1:0] twid_re [8];
  logic [RW-1:0] twid_im [8];

  // Stage advance: a stage may load when it is empty or its content leaves
  always_comb begin
    s2_adv  = !s2_valid_q || bus.out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    in_fire = bus.in_valid && s1_adv;
  end

  assign bus.in_ready = s1_adv;

  // Twiddle candidates for every row; row 0 is a straight bypass
  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    if (gi == 0) begin : g_bypass
      assign twid_re[gi] = s1_re_q;
      assign twid_im[gi] = s1_im_q;
    end else begin : g_mult
      logic [7*W-1:0] m_re;
      logic [7*W-1:0] m_im;
      twid_multi #(.W(W), .K(gi)) u_multi (
        .in_re  (s1_re_q[RW-1:W]),
        .in_im  (s1_im_q[RW-1:W]),
        .out_re (m_re),
        .out_im (m_im)
      );
      assign twid_re[gi] = {m_re, s1_re_q[W-1:0]};
      assign twid_im[gi] = {m_im, s1_im_q[W-1:0]};
    end
  end

  // Row counter and frame-alignment check
  always_comb begin
    row_d = row_q;
    err_d = err_q;
    if (in_fire) begin
      row_d = row_q + 3'd1;
`ifdef TWID_FRAME_CHK_EN
      if (bus.in_last != (row_q == 3'd7)) begin
        err_d = 1'b1;
        // early last: next beat starts a fresh frame
        if (bus.in_last) row_d = 3'd0;
      end
`else
      err_d = 1'b0;
`endif
    end
  end

  // Stage 1 loads the raw row with the row index it was accepted under
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    s1_row_d   = s1_row_q;
    if (s1_adv) s1_valid_d = bus.in_valid;
    if (in_fire) begin
      s1_re_d  = bus.in_re;
      s1_im_d  = bus.in_im;
      s1_row_d = row_q;
    end
  end

  // Stage 2 captures the twiddled row; data only moves with a valid beat
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_re_d    = s2_re_q;
    s2_im_d    = s2_im_q;
    s2_row_d   = s2_row_q;
    s2_last_d  = s2_last_q;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      s2_re_d   = twid_re[s1_row_q];
      s2_im_d   = twid_im[s1_row_q];
      s2_row_d  = s1_row_q;
      s2_last_d = (s1_row_q == 3'd7);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_row_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_re_q    <= '0;
      s2_im_q    <= '0;
      s2_row_q   <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      row_q      <= row_d;
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s1_row_q   <= s1_row_d;
      s2_valid_q <= s2_valid_d;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;
      s2_row_q   <= s2_row_d;
      s2_last_q  <= s2_last_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_re    = s2_re_q;
  assign bus.out_im    = s2_im_q;
  assign bus.out_row   = s2_row_q;
  assign bus.out_last  = s2_last_q;
  assign bus.err       = err_q;
endmodule
